// File: rtl/sha512_pkg.sv
// sha512_pkg
// Shared types and constants for the SHA-512/384 block packer.
//   word_t      : one 64-bit big-endian message word
//   block_t     : one 1024-bit block, [15] is the first word on the wire
//   PAD_MARKER  : word carrying only the leading 1 bit of the padding
//   LEN_IDX_HI/LO : block word indices that carry the 128-bit bit length
//   state_t     : packer state machine encoding
package sha512_pkg;

    typedef logic [63:0]       word_t;
    typedef logic [15:0][63:0] block_t;

    localparam word_t PAD_MARKER = 64'h8000_0000_0000_0000;
    localparam int    LEN_IDX_HI = 1;
    localparam int    LEN_IDX_LO = 0;

    typedef enum logic [1:0] {
        ST_FILL,   // collecting words, in_ready=1
        ST_FULL,   // presenting a mid-message data block
        ST_PADX,   // presenting a final data block with no room for the length
        ST_LAST    // presenting the padded final block
    } state_t;

    // A last-word byte count above 8 is treated as a full word.
    function automatic logic [3:0] clamp_bytes(input logic [3:0] raw);
        return (raw > 4'd8) ? 4'd8 : raw;
    endfunction

endpackage

// File: rtl/sha512_pad_word.sv
// sha512_pad_word
// Builds the final message word: keeps bytes [0, b), writes 8'h80 at byte b
// and zeroes everything after it. Byte 0 is bits [63:56]. With b=8 the word
// passes through unchanged and the marker lands in the following word.
// Ports:
//   data   in  64  raw last message word
//   b      in  4   valid bytes, already clamped to 0..8
//   padded out 64  masked word with the padding marker inserted
module sha512_pad_word
    import sha512_pkg::*;
(
    input  logic [63:0] data,
    input  logic [3:0]  b,
    output logic [63:0] padded
);

    always_comb begin
        // NOTE: assigning a default before any conditional write keeps this
        // block purely combinational; a missing default infers a latch.
        padded = '0;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < b) begin
                padded[63-8*i -: 8] = data[63-8*i -: 8];
            end else if (4'(i) == b) begin
                padded[63-8*i -: 8] = 8'h80;
            end
        end
    end

endmodule

// File: rtl/sha512_block_packer.sv
// sha512_block_packer
// Streaming front end for the SHA-512/384 compression core. Packs big-endian
// 64-bit message words into 1024-bit blocks, tracks the 128-bit bit length and
// emits fully padded final block(s), flagging the first and last block of
// each message.
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   in_valid/in_ready        input word handshake
//   in_data                  message word, first byte in [63:56]
//   in_last, in_bytes        end of message and valid bytes (0..8) of that word
//   blk_valid/blk_ready      output block handshake
//   blk_data                 block as [15:0][63:0], [15] first, [1:0] length
//   blk_first, blk_last      first block of a message / final padded block
//   err                      sticky illegal-input flag (only when the macro
//                            SHA512_PACKER_ERR_EN is defined)
module sha512_block_packer
    import sha512_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [63:0]   in_data,
    input  logic          in_last,
    input  logic [3:0]    in_bytes,
    output logic          blk_valid,
    input  logic          blk_ready,
    output logic [1023:0] blk_data,
    output logic          blk_first,
    output logic          blk_last
`ifdef SHA512_PACKER_ERR_EN
    ,
    output logic          err
`endif
);

    state_t       state;
    logic [3:0]   n;            // next buffer index; index n sits in word 15-n
    logic [124:0] byte_count;
    block_t       blk_q;
    logic         first_pend;
    logic         pad_at_zero;  // length-only block also needs the marker in word 15

    logic [3:0]   b;
    word_t        pad_word;
    logic [3:0]   add_bytes;
    logic [124:0] count_next;
    logic [4:0]   m;            // buffer index of the padding marker, 16 = next block
    logic [127:0] len_next;
    logic [127:0] len_cur;
    block_t       fill_blk;
    block_t       padx_blk;

    assign b         = clamp_bytes(in_bytes);
    assign add_bytes = in_last ? b : 4'd8;

`ifdef SHA512_PACKER_ERR_EN
    logic count_carry;
    assign {count_carry, count_next} = {1'b0, byte_count} + 126'(add_bytes);
`else
    assign count_next = byte_count + 125'(add_bytes);
`endif

    assign m        = {1'b0, n} + {4'd0, (b == 4'd8)};
    assign len_next = {count_next, 3'b000};
    assign len_cur  = {byte_count, 3'b000};
    assign blk_data = blk_q;

    sha512_pad_word u_pad_word (
        .data   (in_data),
        .b      (b),
        .padded (pad_word)
    );

    // Block image loaded when the last word arrives in FILL.
    always_comb begin
        fill_blk = blk_q;
        // Word w holds buffer index 15-w, so w < ~n covers indices after n.
        for (int w = 0; w < 16; w++) begin
            if (4'(w) < ~n) fill_blk[w] = '0;
        end
        fill_blk[~n] = pad_word;
        // A full last word pushes the marker into the following word.
        if (b == 4'd8 && n != 4'd15) fill_blk[~(n + 4'd1)] = PAD_MARKER;
        if (m <= 5'd13) {fill_blk[LEN_IDX_HI], fill_blk[LEN_IDX_LO]} = len_next;
    end

    // Trailing block that carries only the length (and possibly the marker).
    always_comb begin
        padx_blk = '0;
        if (pad_at_zero) padx_blk[15] = PAD_MARKER;
        {padx_blk[LEN_IDX_HI], padx_blk[LEN_IDX_LO]} = len_cur;
    end

    always_ff @(posedge clk) begin
        // NOTE: the block buffer is reset as well because blk_data has a
        // defined reset value; it is a register bank, not a RAM.
        if (rst) begin
            state       <= ST_FILL;
            n           <= '0;
            byte_count  <= '0;
            blk_q       <= '0;
            first_pend  <= 1'b1;
            pad_at_zero <= 1'b0;
            in_ready    <= 1'b1;
            blk_valid   <= 1'b0;
            blk_first   <= 1'b0;
            blk_last    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // samples the pre-edge values regardless of statement order.
            unique case (state)
                ST_FILL: begin
                    if (in_valid && in_ready) begin
                        byte_count <= count_next;
                        if (!in_last) begin
                            blk_q[~n] <= in_data;
                            n         <= n + 4'd1;
                            if (n == 4'd15) begin
                                state     <= ST_FULL;
                                in_ready  <= 1'b0;
                                blk_valid <= 1'b1;
                                blk_first <= first_pend;
                            end
                        end else begin
                            blk_q       <= fill_blk;
                            in_ready    <= 1'b0;
                            blk_valid   <= 1'b1;
                            blk_first   <= first_pend;
                            pad_at_zero <= (m == 5'd16);
                            if (m <= 5'd13) begin
                                state    <= ST_LAST;
                                blk_last <= 1'b1;
                            end else begin
                                state    <= ST_PADX;
                            end
                        end
                    end
                end
                ST_FULL: begin
                    if (blk_valid && blk_ready) begin
                        n          <= '0;
                        blk_q      <= '0;
                        state      <= ST_FILL;
                        in_ready   <= 1'b1;
                        blk_valid  <= 1'b0;
                        blk_first  <= 1'b0;
                        first_pend <= 1'b0;
                    end
                end
                ST_PADX: begin
                    // blk_valid stays high: the length block follows directly.
                    if (blk_valid && blk_ready) begin
                        blk_q      <= padx_blk;
                        state      <= ST_LAST;
                        blk_last   <= 1'b1;
                        blk_first  <= 1'b0;
                        first_pend <= 1'b0;
                    end
                end
                ST_LAST: begin
                    if (blk_valid && blk_ready) begin
                        byte_count <= '0;
                        first_pend <= 1'b1;
                        n          <= '0;
                        blk_q      <= '0;
                        state      <= ST_FILL;
                        in_ready   <= 1'b1;
                        blk_valid  <= 1'b0;
                        blk_first  <= 1'b0;
                        blk_last   <= 1'b0;
                    end
                end
                default: state <= ST_FILL;
            endcase
        end
    end

`ifdef SHA512_PACKER_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (state == ST_FILL && in_valid && in_ready &&
                     ((in_last && in_bytes > 4'd8) || count_carry)) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sha512_block_packer.sv
// tb_sha512_block_packer
// Drives directed and random messages into sha512_block_packer and checks
// every block against a byte-level FIPS 180-4 padding model.
module tb_sha512_block_packer;
    import sha512_pkg::*;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   in_data;
    logic          in_last;
    logic [3:0]    in_bytes;
    logic          blk_valid;
    logic          blk_ready;
    logic [1023:0] blk_data;
    logic          blk_first;
    logic          blk_last;
`ifdef SHA512_PACKER_ERR_EN
    logic          err;
`endif

    int errors = 0;
    int checks = 0;

    word_t         msg_words[$];
    logic [3:0]    last_bytes;
    logic [1023:0] got_blocks[$];

    sha512_block_packer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_bytes  (in_bytes),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_first (blk_first),
        .blk_last  (blk_last)
`ifdef SHA512_PACKER_ERR_EN
        ,
        .err       (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Byte-level FIPS 180-4 padding of the current message, flattened into
    // 64-bit words in transmission order (16 per block).
    task automatic build_expected(output word_t exp_q[$]);
        logic [7:0]   bytes[$];
        logic [127:0] bitlen;
        int           nb;
        word_t        w;
        exp_q.delete();
        for (int i = 0; i < msg_words.size(); i++) begin
            nb = (i == msg_words.size() - 1) ? ((last_bytes > 8) ? 8 : int'(last_bytes)) : 8;
            for (int k = 0; k < nb; k++) bytes.push_back(msg_words[i][63-8*k -: 8]);
        end
        bitlen = 128'(bytes.size()) * 128'd8;
        bytes.push_back(8'h80);
        while (bytes.size() % 128 != 112) bytes.push_back(8'h00);
        for (int k = 15; k >= 0; k--) bytes.push_back(bitlen[8*k +: 8]);
        for (int j = 0; j < bytes.size() / 8; j++) begin
            for (int k = 0; k < 8; k++) w[63-8*k -: 8] = bytes[8*j + k];
            exp_q.push_back(w);
        end
    endtask

    task automatic set_random_msg(input int nw, input logic [3:0] lb);
        msg_words.delete();
        for (int i = 0; i < nw; i++) msg_words.push_back({$urandom, $urandom});
        last_bytes = lb;
    endtask

    // Streams msg_words in and checks each block. Entered and left at a
    // negedge. stall_cycles holds blk_ready low on the first block.
    task automatic run_message(input string name, input int stall_cycles, input bit rnd);
        word_t         exp_q[$];
        block_t        blk;
        logic [1023:0] hold;
        int nw, nblk, got, wi, cyc, stall_left;
        bit expect_valid, done;
        build_expected(exp_q);
        nw = msg_words.size();
        nblk = exp_q.size() / 16;
        got = 0; wi = 0; cyc = 0; stall_left = stall_cycles;
        expect_valid = 0; done = 0; hold = '0;
        got_blocks.delete();
        while (!done) begin
            if (expect_valid) begin
                check({name, "_no_bubble"}, 64'(blk_valid), 64'd1);
                expect_valid = 0;
            end
            in_valid = (wi < nw) && (!rnd || $urandom_range(3) != 0);
            in_data  = (wi < nw) ? msg_words[wi] : {$urandom, $urandom};
            in_last  = (wi == nw - 1);
            in_bytes = in_last ? last_bytes : 4'($urandom);
            if (blk_valid && got == 0 && stall_left > 0) begin
                if (stall_left == stall_cycles) hold = blk_data;
                else check({name, "_stall_data_stable"}, 64'(blk_data === hold), 64'd1);
                check({name, "_stall_in_ready"}, 64'(in_ready), 64'd0);
                blk_ready = 1'b0;
                stall_left--;
            end else begin
                blk_ready = !rnd || ($urandom_range(2) != 0);
            end
            if (blk_valid && blk_ready) begin
                if (got < nblk) begin
                    blk = blk_data;
                    for (int j = 0; j < 16; j++)
                        check($sformatf("%s_blk%0d_w%0d", name, got, 15 - j), blk[15-j], exp_q[16*got + j]);
                    check($sformatf("%s_blk%0d_first", name, got), 64'(blk_first), 64'(got == 0));
                    check($sformatf("%s_blk%0d_last", name, got), 64'(blk_last), 64'(got == nblk - 1));
                    got_blocks.push_back(blk_data);
                    if (got + 1 == nblk - 1 && nw <= 16 * (got + 1)) expect_valid = 1;
                    got++;
                    if (got == nblk) done = 1;
                end else begin
                    check({name, "_block_count"}, 64'(got), 64'(nblk - 1));
                    done = 1;
                end
            end
            if (in_valid && in_ready) wi++;
            @(negedge clk);
            cyc++;
            if (!done && cyc > 3000) begin
                check({name, "_timeout_blocks_seen"}, 64'(got), 64'(nblk));
                done = 1;
            end
        end
        check({name, "_words_consumed"}, 64'(wi), 64'(nw));
        in_valid  = 1'b0;
        in_last   = 1'b0;
        blk_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        block_t b0;
        block_t b1;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        in_bytes = '0; blk_ready = 1'b0; last_bytes = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_blk_valid", 64'(blk_valid), 64'd0);
        check("rst_blk_first", 64'(blk_first), 64'd0);
        check("rst_blk_last",  64'(blk_last),  64'd0);
        b0 = blk_data;
        for (int j = 0; j < 16; j++) check($sformatf("rst_blk_data_w%0d", j), b0[j], 64'd0);

        // Empty message: data must be fully masked
        set_random_msg(1, 4'd0);
        run_message("empty", 0, 0);
        b0 = got_blocks[0];
        check("empty_w15_marker", b0[15], PAD_MARKER);
        check("empty_len", b0[0], 64'd0);

        // "abc"
        msg_words.delete();
        msg_words.push_back(64'h6162_6300_0000_0000);
        last_bytes = 4'd3;
        run_message("abc", 0, 0);
        b0 = got_blocks[0];
        check("abc_w15", b0[15], 64'h6162_6380_0000_0000);
        check("abc_len_lo", b0[0], 64'h18);
        check("abc_len_hi", b0[1], 64'h0);

        // 14 full words: marker at index 14, length spills to a second block
        set_random_msg(14, 4'd8);
        run_message("w14", 0, 0);
        b0 = got_blocks[0];
        b1 = got_blocks[1];
        check("w14_a_w1_marker", b0[1], PAD_MARKER);
        check("w14_a_w0", b0[0], 64'd0);
        check("w14_b_len", b1[0], 64'h380);

        // 16 full words: marker opens the trailing block
        set_random_msg(16, 4'd8);
        run_message("w16", 0, 0);
        b1 = got_blocks[1];
        check("w16_b_w15_marker", b1[15], PAD_MARKER);
        check("w16_b_len", b1[0], 64'h400);

        // 17 words with a 5-cycle stall on the first block
        set_random_msg(17, 4'd5);
        run_message("w17_stall", 5, 0);

        // Random messages with random backpressure, input gaps and byte counts
        for (int t = 0; t < 20; t++) begin
            set_random_msg($urandom_range(1, 40), 4'($urandom_range(0, 15)));
            run_message($sformatf("rnd%0d", t), (t % 4 == 0) ? 3 : 0, 1);
        end

        // Reset while the final block is stalled
        in_valid = 1'b1; in_data = 64'h6162_6300_0000_0000;
        in_last = 1'b1; in_bytes = 4'd3; blk_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        check("rstlast_pre_valid", 64'(blk_valid), 64'd1);
        check("rstlast_pre_last",  64'(blk_last),  64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rstlast_blk_valid", 64'(blk_valid), 64'd0);
        check("rstlast_in_ready",  64'(in_ready),  64'd1);
        check("rstlast_blk_last",  64'(blk_last),  64'd0);
        rst = 1'b0;
        @(negedge clk);
        msg_words.delete();
        msg_words.push_back(64'h6162_6300_0000_0000);
        last_bytes = 4'd3;
        run_message("abc_after_rst", 0, 0);
        b0 = got_blocks[0];
        check("abc_after_rst_len", b0[0], 64'h18);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sha512_block_packer.md
# sha512_block_packer

Streaming front end for the SHA-512/384 hash datapath. Accepts a message as big-endian 64-bit words with a last-word byte count, tracks the 128-bit bit length, and produces 1024-bit blocks. The final block or blocks are fully FIPS 180-4 padded, so the downstream compression core consumes them unchanged. The block also flags the first block of a message, so the core loads its IV, and the last block, so the core marks its digest valid.

## Interface
Parameters: none. Widths are fixed by SHA-512.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  packer can accept a word
- in_data  in  64  message word, first byte in bits [63:56]
- in_last  in  1  this word ends the message
- in_bytes  in  4  valid bytes in the last word, 0..8; ignored unless in_last
- blk_valid  out  1  blk_data holds a block
- blk_ready  in  1  consumer takes the block
- blk_data  out  1024  block as [15:0][63:0]; [15] is the first word, [1:0] hold the length ({[1],[0]} = 128-bit bit count)
- blk_first  out  1  block is the first of its message
- blk_last  out  1  block is the final padded block
- err  out  1  sticky illegal-input flag; present only with SHA512_PACKER_ERR_EN

Reset values: in_ready=1, blk_valid=0, blk_first=0, blk_last=0, blk_data=0, err=0.

## Operation
- State machine states:
  - FILL: in_ready=1, blk_valid=0.
  - FULL: emits a mid-message data block.
  - PADX: emits a final data block that has no room for the length.
  - LAST: emits the padded final block.
- Transfers: an input transfer is in_valid&in_ready; a block transfer is blk_valid&blk_ready.
- FILL, non-last word: write the word to buffer index n, where n counts 0..15 and maps to blk_data[15-n]. Then n++ and byte_count += 8. On n=15 go to FULL.
- FILL, last word, with b = min(in_bytes, 8):
  - Word n becomes in_data with byte b set to 8'h80 and bytes after b zeroed. When b=8 the word is kept as is.
  - Words after n are zeroed. byte_count += b.
  - Marker index m = n if b<8, else n+1. When m≤15, word m = 64'h8000_0000_0000_0000.
  - If m≤13: words [1:0] = byte_count×8 (the updated count), go to LAST.
  - Otherwise go to PADX.
- FULL, on block transfer: n=0, buffer cleared, go to FILL.
- PADX, on block transfer: buffer is all zero plus the length in [1:0]. If m=16, index 0 also gets 64'h8000_0000_0000_0000. Go to LAST.
- LAST, on block transfer: byte_count=0, first_pend=1, n=0, go to FILL.
- blk_first = first_pend. first_pend is set at reset and after LAST, and cleared on any block transfer.
- blk_last = (state==LAST).
- Arithmetic: byte_count is a 125-bit register; length = {byte_count, 3'b000}. Wrap-around is modulo 2^128 bits, with no saturation.
- An empty message is a single beat with in_last=1 and in_bytes=0.

## Timing
- The word accepted at edge t that fills index 15 or carries in_last gives blk_valid=1 from cycle t+1.
- blk_valid, blk_data, blk_first and blk_last are registered. They are held stable while blk_valid & ~blk_ready.
- in_ready=0 in FULL, PADX and LAST. in_ready returns to 1 the cycle after a FULL or LAST transfer.
- PADX→LAST: blk_valid stays 1 without a bubble, and the length block is presented the cycle after the PADX transfer.
- Sustained rate: 16 words per 17 cycles when blk_ready is held 1.
- rst has priority in any state: the partial block and the length are discarded, and the next message starts with blk_first=1.

## Configuration
- SHA512_PACKER_ERR_EN defined: the err port exists.
  - err is set when in_last & in_bytes>8, or when byte_count wraps.
  - err clears only on rst.
- Undefined: no err port.
- In both cases in_bytes>8 is treated as 8.

## Structure
- sha512_pkg holds:
  - word_t (logic [63:0]) and block_t (logic [15:0][63:0])
  - PAD_MARKER = 64'h8000_0000_0000_0000
  - LEN_IDX_HI=1, LEN_IDX_LO=0
  - the state enum
- One combinational sub-module, sha512_pad_word: (in_data, b) → masked word with 8'h80 inserted at byte b.

## Test plan
- Empty message (in_last, in_bytes=0) → one block, [15]=64'h8000000000000000, all other words 0, blk_first=blk_last=1.
- "abc" (in_data=64'h6162630000000000, in_bytes=3, in_last) → one block, [15]=64'h6162638000000000, [0]=64'h18, [1]=0.
- 14 words, the last with in_bytes=8 (m=14) → two blocks:
  - block A: first=1, last=0, [1]=PAD_MARKER, [0]=0.
  - block B: last=1, all zero except [0]=64'h380.
- 16 full words, the last with in_bytes=8 → two blocks:
  - block A: all data.
  - block B: [15]=PAD_MARKER, [0]=64'h400, no bubble between A and B.
- 17-word message with blk_ready held low 5 cycles on the first block:
  - first block: blk_data stable and in_ready=0 during the stall.
  - second block: blk_first=0, blk_last=1.
- rst asserted while in LAST with blk_ready=0 → next cycle blk_valid=0, in_ready=1. A following "abc" message yields blk_first=1 and [0]=64'h18.
